// File: rtl/clk_en_pkg.sv
// Shared types, defaults and helpers for the multi-channel clock-enable generator.
package clk_en_pkg;

    localparam int CNT_W_DEF = 16;
    localparam int CH_W_DEF  = 8;

    // A divisor-write request as seen by the configuration port.
    typedef struct packed {
        logic [CH_W_DEF-1:0]  ch;
        logic [CNT_W_DEF-1:0] div;
    } cfg_req_t;

    // Divisors 0 and 1 both mean "every cycle".
    function automatic logic [31:0] eff_div(input logic [31:0] div);
        return (div == 32'd0) ? 32'd1 : div;
    endfunction

endpackage

// File: rtl/clk_en_ch.sv
// One divide-by-N enable channel: counter, active/shadow divisor with
// period-boundary hand-over, and registered tick/level outputs.
module clk_en_ch
    import clk_en_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int DEFAULT_DIV = 2
)(
    input  logic             CLK,
    input  logic             RST,
    input  logic             en,
    input  logic             sync,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_div,
    output logic             tick,
    output logic             level,
    output logic             pend
);

    localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    logic [CNT_W-1:0] ctr_q, ctr_d;
    logic [CNT_W-1:0] div_act_q, div_act_d;
    logic [CNT_W-1:0] div_shadow_q, div_shadow_d;
    logic             pend_q, pend_d;
    logic             tick_q, tick_d;
    logic             level_q, level_d;

    logic [CNT_W-1:0] d_last;
    logic [CNT_W-1:0] d_half;
    logic             wrap;

    // Terminal count and level threshold derived from the active divisor.
    always_comb begin
        d_last = CNT_W'(eff_div(32'(div_act_q))) - ONE;
        d_half = d_last >> 1;
        wrap   = en && (ctr_q == d_last);
    end

    // Next-state: sync restarts everything, otherwise count and hand over at the wrap.
    always_comb begin
        ctr_d        = ctr_q;
        div_act_d    = div_act_q;
        div_shadow_d = div_shadow_q;
        pend_d       = pend_q;
        tick_d       = 1'b0;
        level_d      = 1'b0;

        if (sync) begin
            // Restart in phase; any shadowed or simultaneously written divisor applies now.
            ctr_d  = '0;
            pend_d = 1'b0;
            if (wr) begin
                div_shadow_d = wr_div;
                div_act_d    = wr_div;
            end else begin
                div_act_d    = div_shadow_q;
            end
        end else begin
            if (en) begin
                ctr_d   = wrap ? '0 : ctr_q + ONE;
                tick_d  = wrap;
                // Phase of the coming cycle equals its counter value; high in the upper half.
                level_d = (ctr_d > d_half);
            end else begin
                ctr_d   = '0;
            end

            // A write landing on a wrap is only shadowed; it applies at the following wrap.
            if (wr) begin
                div_shadow_d = wr_div;
                pend_d       = 1'b1;
            end else if (pend_q && (wrap || !en)) begin
                div_act_d    = div_shadow_q;
                pend_d       = 1'b0;
            end
        end
    end

    // Channel state register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ctr_q        <= '0;
            div_act_q    <= DEF_DIV;
            div_shadow_q <= DEF_DIV;
            pend_q       <= 1'b0;
            tick_q       <= 1'b0;
            level_q      <= 1'b0;
        end else begin
            ctr_q        <= ctr_d;
            div_act_q    <= div_act_d;
            div_shadow_q <= div_shadow_d;
            pend_q       <= pend_d;
            tick_q       <= tick_d;
            level_q      <= level_d;
        end
    end

    assign tick  = tick_q;
    assign level = level_q;
    assign pend  = pend_q;

endmodule

// File: rtl/clk_en_gen.sv
// Multi-channel clock-enable generator: NUM_CH independent divide-by-N tick/level
// streams in the CLK domain, with a single-outstanding divisor-write port.
module clk_en_gen
    import clk_en_pkg::*;
#(
    parameter  int NUM_CH      = 4,
    parameter  int CNT_W       = CNT_W_DEF,
    parameter  int DEFAULT_DIV = 2,
    localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
)(
    input  logic              CLK,
    input  logic              RST,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              sync_in,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] level
);

    logic              accept;
    logic [NUM_CH-1:0] wr;
    logic [NUM_CH-1:0] pend;

    // Ready depends only on registered pending flags, never on the cfg inputs.
    assign cfg_ready = ~|pend;
    assign accept    = cfg_valid & cfg_ready;

    // One-hot write strobe; an out-of-range index is accepted but selects nothing.
    always_comb begin
        wr = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (accept && (int'(cfg_ch) == i)) begin
                wr[i] = 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        clk_en_ch #(
            .CNT_W       (CNT_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .CLK    (CLK),
            .RST    (RST),
            .en     (ch_en[g]),
            .sync   (sync_in),
            .wr     (wr[g]),
            .wr_div (cfg_div),
            .tick   (tick[g]),
            .level  (level[g]),
            .pend   (pend[g])
        );
    end

endmodule

// File: doc/clk_en_gen.md
# clk_en_gen

Multi-channel clock-enable generator: the parametrised successor to the single-output divided-clock block. It produces NUM_CH independent divide-by-N enable streams (one-cycle `tick` pulses plus a registered square-wave `level`), all in the single `CLK` domain, so no derived clock nets reach fabric routing. Each channel's divisor is reprogrammable at run time through a valid/ready port, with glitch-free hand-over at the period boundary. A global `sync_in` re-phases all channels. It sits beside the core and feeds the UART, display-scan and timer blocks.

## Interface
- `NUM_CH`, default 4: number of channels, ≥1.
- `CNT_W`, default 16: divisor/counter width in bits.
- `DEFAULT_DIV`, default 2: divisor loaded into every channel at reset.
- `CLK` in, 1: the only clock; all logic samples on its rising edge.
- `RST` in, 1: synchronous, active-high reset.
- `ch_en` in, NUM_CH: per-channel run enable.
- `sync_in` in, 1: one-cycle request to restart all channels in phase.
- `cfg_valid` in, 1: divisor-write request.
- `cfg_ready` out, 1: the block can accept a divisor write.
- `cfg_ch` in, max(1,$clog2(NUM_CH)): target channel index.
- `cfg_div` in, CNT_W: new divisor, unsigned.
- `tick` out, NUM_CH: one-cycle enable pulse per period.
- `level` out, NUM_CH: square wave with period = divisor.

## Operation
- **Per-channel state:** `ctr` (CNT_W), `div_act` (active divisor), `div_shadow`, `pend`.
- **Effective divisor:** d = max(div_act, 1). Values 0 and 1 both mean "every cycle".
- **Enabled channel** (`ch_en[i]`=1), on each edge:
  - `ctr` <= (`ctr`==d-1) ? 0 : `ctr`+1.
  - `tick[i]` <= (`ctr`==d-1).
- **Phase index p:** define p=0 in each `tick` cycle. `level[i]` is high when p > (d-1)/2 (integer division).
  - Even d: high for d/2 cycles, low for d/2.
  - Odd d: high for (d-1)/2 cycles, low for (d+1)/2.
  - `level` falls in the `tick` cycle.
  - d=1: `tick` is constantly 1 and `level` is constantly 0.
- **Disabled channel:** `ctr` is held at 0; `tick` and `level` are registered low on the next edge. On re-enable, the channel counts from 0.
- **Configuration handshake:**
  - A write is accepted on an edge with `cfg_valid` & `cfg_ready`. Accepted: `div_shadow[cfg_ch]` <= `cfg_div`, `pend[cfg_ch]` <= 1.
  - `cfg_ready` = ~|`pend` (registered state only; no combinational path from `cfg_*`). Consequence: at most one outstanding update block-wide.
  - `cfg_ch` ≥ NUM_CH: the write is accepted and discarded; no state changes.
- **Hand-over:** on the edge where channel i wraps (`ctr`==d-1 and enabled), `div_act` <= `div_shadow` and `pend` <= 0.
  - If the channel is disabled while pending, the hand-over happens on the first edge with `ch_en`=0, so `cfg_ready` is never stuck.
- **Simultaneous events:**
  - Accept and wrap on the same channel and edge: the new value is shadowed only. It applies at the next wrap, not this one.
  - `sync_in`=1: every channel loads `ctr`<=0. Any pending `div_shadow` becomes active immediately and `pend` is cleared. `tick` and `level` are registered 0 that edge.
  - `sync_in` together with an accept: the accepted value goes directly to `div_act` and `pend` stays 0.
  - `RST` overrides everything.
- **Reset values:**
  - `ctr`=0, `div_act`=`div_shadow`=DEFAULT_DIV, `pend`=0.
  - `tick`=0, `level`=0, `cfg_ready`=1.
  - A write in flight is dropped by `RST`.

## Timing
- `tick` and `level` are flop outputs with no input-to-output combinational path.
- Cycle 1 is the first cycle after `RST` deasserts with `ch_en[i]` high. `ctr` is 0 in cycle 1, and the first `tick` is in cycle d+1. After that, `tick` repeats every d cycles.
- Divisor change latency: accept at edge k. The new period starts at the first wrap after k, giving a period of ≤ old d + 1 cycles. No runt or stretched pulse beyond that.
- `cfg_ready` returns high the cycle after hand-over.
- `sync_in` at edge k: all enabled channels tick together at cycle k + d_i + 1. Identical divisors give identical phase.

## Structure
- Package `clk_en_pkg` holds:
  - `localparam` default `CNT_W`.
  - `typedef struct packed {ch, div}` `cfg_req_t`.
  - Function `eff_div(div)` returning max(div, 1).
- Sub-module `clk_en_ch`, instantiated NUM_CH times via generate. It owns `ctr`/`div_act`/`div_shadow`/`pend`/`tick`/`level` and takes `wr`, `wr_div`, `sync`, `en`.
- The top level decodes `cfg_ch` into a one-hot `wr` and reduces `pend` into `cfg_ready`.
- Target size: about 200 lines of RTL.

## Test plan
- **Reset and default:** RST for 3 cycles, then `ch_en`=4'b0001, DEFAULT_DIV=2. Expect `tick[0]` in cycles 3, 5, 7…; `level[0]` alternating 0/1; other channels all 0.
- **Odd divisor:** write ch1 div=5, then `sync_in`. Expect `tick[1]` every 5 cycles and `level[1]` high for 2 of every 5 cycles, falling in the tick cycle.
- **Glitch-free change:**
  - ch0 at div=6; write div=3 at ctr=2. Expect remaining ticks at period 6, then period 3 after the wrap.
  - `cfg_ready` is low from accept until the cycle after the wrap.
  - A second write while not ready is not accepted (`cfg_valid` held).
- **Edge divisors:** div=0 and div=1 give `tick` constantly 1 and `level` 0. div=2^CNT_W-1 gives the correct period with no counter overflow.
- **Simultaneous events:**
  - Accept and wrap on the same edge: the new div applies one period later.
  - `sync_in` with a pending update: immediate apply, all channels aligned.
  - `ch_en` dropped mid-period: `tick`/`level` are 0 next cycle, and the restart counts from 0.
- **Reset mid-operation:** assert RST with `pend`=1 and `ctr`≠0. Next cycle expect all outputs 0, `cfg_ready`=1, and divisor back to DEFAULT_DIV.
